// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/flush controller for the 5-stage RV32I core
// Load-use, branch redirect, I-miss redirect hold, D-miss freeze and perf counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             id_flush,
  input  logic [31:0]      id_target,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_target,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             hazard_mux,
  output logic             back_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] IWAIT   = 2'd1;
  localparam logic [1:0] IWAIT_R = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [31:0]      redir_q, redir_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use;
  logic             lu_stall;
  logic             stall_evt;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  always_comb begin
    pc_write    = 1'b1;
    pc_redirect = 1'b0;
    redirect_pc = 32'd0;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    hazard_mux  = 1'b0;
    back_stall  = 1'b0;
    lu_stall    = 1'b0;
    state_d     = state_q;
    redir_d     = redir_q;

    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      hazard_mux = 1'b1;
    end else if (dcache_stall) begin
      // Whole pipe frozen: nothing advances, nothing is captured.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      back_stall = 1'b1;
    end else if ((state_q == IWAIT_R) && !icache_stall) begin
      pc_redirect = 1'b1;
      redirect_pc = redir_q;
      ifid_flush  = 1'b1;
      hazard_mux  = 1'b1;
      state_d     = RUN;
    end else if (icache_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      hazard_mux = 1'b1;
      if (state_q != IWAIT_R) begin
        if (ex_branch_taken) begin
          // The PC cannot load during the miss, so park the target until fetch resumes.
          redir_d    = ex_target;
          ifid_flush = 1'b1;
          state_d    = IWAIT_R;
        end else begin
          state_d = IWAIT;
        end
      end
    end else begin
      state_d = RUN;
      if (ex_branch_taken) begin
        pc_redirect = 1'b1;
        redirect_pc = ex_target;
        ifid_flush  = 1'b1;
        hazard_mux  = 1'b1;
      end else if (load_use) begin
        hazard_mux = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        lu_stall   = 1'b1;
      end else if (id_flush) begin
        pc_redirect = 1'b1;
        redirect_pc = id_target;
        ifid_flush  = 1'b1;
      end
    end
  end

  assign stall_evt = icache_stall || dcache_stall || lu_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      redir_q     <= 32'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      redir_q <= redir_d;
      if (stall_evt && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (pc_redirect && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
// Directed scenarios plus randomized traffic against a rule-level reference model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_stall, dcache_stall;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_memread;
  logic        id_flush, ex_branch_taken;
  logic [31:0] id_target, ex_target;

  logic        pc_write, pc_redirect, ifid_write, ifid_flush, hazard_mux, back_stall;
  logic [31:0] redirect_pc, stall_cnt, flush_cnt;

  logic        s_pc_write, s_pc_redirect, s_ifid_write, s_ifid_flush, s_hazard_mux, s_back_stall;
  logic [31:0] s_redirect_pc;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_flush(id_flush), .id_target(id_target),
    .ex_branch_taken(ex_branch_taken), .ex_target(ex_target),
    .pc_write(pc_write), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .hazard_mux(hazard_mux),
    .back_stall(back_stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .id_flush(id_flush), .id_target(id_target),
    .ex_branch_taken(ex_branch_taken), .ex_target(ex_target),
    .pc_write(s_pc_write), .pc_redirect(s_pc_redirect), .redirect_pc(s_redirect_pc),
    .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .hazard_mux(s_hazard_mux),
    .back_stall(s_back_stall), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // {pc_write, pc_redirect, ifid_write, ifid_flush, hazard_mux, back_stall}
  logic [5:0] obs, obs_s;
  assign obs   = {pc_write, pc_redirect, ifid_write, ifid_flush, hazard_mux, back_stall};
  assign obs_s = {s_pc_write, s_pc_redirect, s_ifid_write, s_ifid_flush, s_hazard_mux, s_back_stall};

  // Reference model: only "is a redirect parked" matters for outputs.
  logic        m_pend    = 1'b0;
  logic [31:0] m_pend_pc = 32'd0;
  longint      m_stall   = 0;
  longint      m_flush   = 0;
  int          m_stall_s = 0;
  int          m_flush_s = 0;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] rpc;
    logic        stall_ev;
  } exp_t;

  function automatic exp_t predict();
    exp_t e;
    logic lu;
    lu = ex_memread && (ex_rd != 0) &&
         ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    e.ctl = 6'b101000;
    e.rpc = 32'd0;
    e.stall_ev = icache_stall | dcache_stall;
    if (rst) begin
      e.ctl = 6'b000110;
      e.stall_ev = 1'b0;
    end else if (dcache_stall) begin
      e.ctl = 6'b000001;
    end else if (m_pend && !icache_stall) begin
      e.ctl = 6'b111110;
      e.rpc = m_pend_pc;
    end else if (icache_stall) begin
      e.ctl = (ex_branch_taken && !m_pend) ? 6'b000110 : 6'b000010;
    end else if (ex_branch_taken) begin
      e.ctl = 6'b111110;
      e.rpc = ex_target;
    end else if (lu) begin
      e.ctl = 6'b000010;
      e.stall_ev = 1'b1;
    end else if (id_flush) begin
      e.ctl = 6'b111100;
      e.rpc = id_target;
    end
    return e;
  endfunction

  task automatic model_advance(input exp_t e);
    if (rst) begin
      m_pend = 1'b0; m_pend_pc = 32'd0;
      m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else begin
      if (!dcache_stall) begin
        if (m_pend && !icache_stall) m_pend = 1'b0;
        else if (icache_stall && ex_branch_taken && !m_pend) begin
          m_pend = 1'b1;
          m_pend_pc = ex_target;
        end
      end
      if (e.stall_ev) begin
        if (m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
        if (m_stall_s < 7) m_stall_s = m_stall_s + 1;
      end
      if (e.ctl[4]) begin
        if (m_flush < 64'hFFFF_FFFF) m_flush = m_flush + 1;
        if (m_flush_s < 7) m_flush_s = m_flush_s + 1;
      end
    end
  endtask

  task automatic tick();
    exp_t e;
    e = predict();
    @(posedge clk);
    model_advance(e);
    #1;
  endtask

  task automatic clr_inputs();
    icache_stall = 0; dcache_stall = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0; id_flush = 0;
    ex_branch_taken = 0; id_target = 0; ex_target = 0;
    #1;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst = 1; tick(); rst = 0; #1;
  endtask

  task automatic test_reset();
    rst = 1; clr_inputs();
    tick(); tick();
    n_chk++; if (obs !== 6'b000110 || redirect_pc !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs: got ctl=%b rpc=%h want ctl=000110 rpc=0", obs, redirect_pc);
    end
    rst = 0; #1;
    n_chk++; if (stall_cnt !== 0 || flush_cnt !== 0) begin
      n_fail++; $display("FAIL reset_counters: got stall=%0d flush=%0d want 0/0", stall_cnt, flush_cnt);
    end
    n_chk++; if (obs !== 6'b101000) begin
      n_fail++; $display("FAIL idle_defaults: got ctl=%b want 101000", obs);
    end
  endtask

  task automatic test_load_use();
    longint s0;
    s0 = m_stall;
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; #1;
    n_chk++; if (obs !== 6'b000010) begin
      n_fail++; $display("FAIL load_use_rs1: got ctl=%b want 000010", obs);
    end
    tick();
    n_chk++; if (stall_cnt !== 32'(s0 + 1)) begin
      n_fail++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, s0 + 1);
    end
    clr_inputs();
    ex_memread = 1; id_rs2 = 9; ex_rd = 9; id_use_rs2 = 1; #1;
    n_chk++; if (obs !== 6'b000010) begin
      n_fail++; $display("FAIL load_use_rs2: got ctl=%b want 000010", obs);
    end
    tick();
    clr_inputs();
    s0 = m_stall;
    ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #1;
    n_chk++; if (obs !== 6'b101000) begin
      n_fail++; $display("FAIL load_use_x0: got ctl=%b want 101000", obs);
    end
    tick();
    n_chk++; if (stall_cnt !== 32'(s0)) begin
      n_fail++; $display("FAIL load_use_x0_cnt: got %0d want %0d", stall_cnt, s0);
    end
    clr_inputs();
  endtask

  task automatic test_branch();
    longint f0, s0;
    f0 = m_flush; s0 = m_stall;
    ex_branch_taken = 1; ex_target = 32'h100;
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    id_flush = 1; id_target = 32'h40; #1;
    n_chk++; if (obs !== 6'b111110 || redirect_pc !== 32'h100) begin
      n_fail++; $display("FAIL branch_redirect: got ctl=%b rpc=%h want 111110 rpc=100", obs, redirect_pc);
    end
    tick();
    n_chk++; if (flush_cnt !== 32'(f0 + 1) || stall_cnt !== 32'(s0)) begin
      n_fail++; $display("FAIL branch_cnt: got flush=%0d stall=%0d want %0d/%0d", flush_cnt, stall_cnt, f0 + 1, s0);
    end
    clr_inputs();
  endtask

  task automatic test_jal();
    id_flush = 1; id_target = 32'h40; #1;
    n_chk++; if (obs !== 6'b111100 || redirect_pc !== 32'h40) begin
      n_fail++; $display("FAIL jal_redirect: got ctl=%b rpc=%h want 111100 rpc=40", obs, redirect_pc);
    end
    tick();
    clr_inputs();
  endtask

  task automatic test_imiss_branch();
    do_reset();
    icache_stall = 1; #1;
    n_chk++; if (obs !== 6'b000010) begin
      n_fail++; $display("FAIL imiss_c1: got ctl=%b want 000010", obs);
    end
    tick();
    ex_branch_taken = 1; ex_target = 32'h200; id_flush = 1; #1;
    n_chk++; if (obs !== 6'b000110) begin
      n_fail++; $display("FAIL imiss_capture: got ctl=%b want 000110", obs);
    end
    tick();
    ex_target = 32'h300; #1;
    n_chk++; if (obs !== 6'b000010) begin
      n_fail++; $display("FAIL imiss_second_branch: got ctl=%b want 000010", obs);
    end
    tick();
    ex_branch_taken = 0; tick();
    icache_stall = 0; id_flush = 1; id_target = 32'h40; #1;
    n_chk++; if (obs !== 6'b111110 || redirect_pc !== 32'h200) begin
      n_fail++; $display("FAIL imiss_release: got ctl=%b rpc=%h want 111110 rpc=200", obs, redirect_pc);
    end
    tick();
    n_chk++; if (stall_cnt !== 4 || flush_cnt !== 1) begin
      n_fail++; $display("FAIL imiss_cnt: got stall=%0d flush=%0d want 4/1", stall_cnt, flush_cnt);
    end
    clr_inputs();
    n_chk++; if (obs !== 6'b101000) begin
      n_fail++; $display("FAIL imiss_back_to_run: got ctl=%b want 101000", obs);
    end
    tick();
  endtask

  task automatic test_dmiss_priority();
    do_reset();
    dcache_stall = 1; icache_stall = 1; ex_branch_taken = 1; ex_target = 32'h300; #1;
    n_chk++; if (obs !== 6'b000001 || redirect_pc !== 0) begin
      n_fail++; $display("FAIL dmiss_freeze: got ctl=%b rpc=%h want 000001 rpc=0", obs, redirect_pc);
    end
    tick();
    n_chk++; if (stall_cnt !== 1 || flush_cnt !== 0) begin
      n_fail++; $display("FAIL dmiss_cnt: got stall=%0d flush=%0d want 1/0", stall_cnt, flush_cnt);
    end
    dcache_stall = 0; #1;
    n_chk++; if (obs !== 6'b000110) begin
      n_fail++; $display("FAIL dmiss_release_rule3: got ctl=%b want 000110", obs);
    end
    tick();
    icache_stall = 0; ex_branch_taken = 0; dcache_stall = 1; #1;
    n_chk++; if (obs !== 6'b000001) begin
      n_fail++; $display("FAIL dmiss_holds_redirect: got ctl=%b want 000001", obs);
    end
    tick();
    dcache_stall = 0; #1;
    n_chk++; if (obs !== 6'b111110 || redirect_pc !== 32'h300) begin
      n_fail++; $display("FAIL dmiss_then_redirect: got ctl=%b rpc=%h want 111110 rpc=300", obs, redirect_pc);
    end
    tick();
    clr_inputs();
  endtask

  task automatic test_reset_mid_redirect();
    do_reset();
    icache_stall = 1; ex_branch_taken = 1; ex_target = 32'h200; tick();
    rst = 1; #1;
    n_chk++; if (obs !== 6'b000110 || redirect_pc !== 0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got ctl=%b rpc=%h want 000110 rpc=0", obs, redirect_pc);
    end
    tick();
    rst = 0; clr_inputs();
    n_chk++; if (obs !== 6'b101000 || stall_cnt !== 0 || flush_cnt !== 0) begin
      n_fail++; $display("FAIL rst_mid_state: got ctl=%b stall=%0d flush=%0d want 101000 0/0", obs, stall_cnt, flush_cnt);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    icache_stall = 1;
    for (int i = 0; i < 10; i++) tick();
    n_chk++; if (s_stall_cnt !== 3'd7 || stall_cnt !== 10) begin
      n_fail++; $display("FAIL stall_saturate: got small=%0d wide=%0d want 7/10", s_stall_cnt, stall_cnt);
    end
    clr_inputs();
    for (int i = 0; i < 9; i++) begin
      id_flush = 1; id_target = 32'(i * 4); tick();
    end
    n_chk++; if (s_flush_cnt !== 3'd7 || flush_cnt !== 9) begin
      n_fail++; $display("FAIL flush_saturate: got small=%0d wide=%0d want 7/9", s_flush_cnt, flush_cnt);
    end
    clr_inputs();
  endtask

  task automatic test_random();
    exp_t e;
    int errs;
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      rst             = ($urandom_range(0, 63) == 0);
      icache_stall    = ($urandom_range(0, 3) == 0);
      dcache_stall    = ($urandom_range(0, 7) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      id_flush        = ($urandom_range(0, 5) == 0);
      ex_memread      = $urandom_range(0, 1);
      ex_rd           = 5'($urandom_range(0, 3));
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_use_rs1      = $urandom_range(0, 1);
      id_use_rs2      = $urandom_range(0, 1);
      id_target       = $urandom;
      ex_target       = $urandom;
      #1;
      e = predict();
      n_chk++; if (obs !== e.ctl || redirect_pc !== e.rpc || obs_s !== e.ctl) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_out[%0d]: got ctl=%b rpc=%h want ctl=%b rpc=%h", i, obs, redirect_pc, e.ctl, e.rpc);
      end
      n_chk++; if (stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush) ||
                   s_stall_cnt !== 3'(m_stall_s) || s_flush_cnt !== 3'(m_flush_s)) begin
        n_fail++; errs++;
        if (errs < 10) $display("FAIL rand_cnt[%0d]: got %0d/%0d %0d/%0d want %0d/%0d %0d/%0d", i,
                                stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt, m_stall, m_flush, m_stall_s, m_flush_s);
      end
      tick();
    end
    rst = 0; clr_inputs();
  endtask

  initial begin
    rst = 1;
    clr_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_jal();
    test_imiss_branch();
    test_dmiss_priority();
    test_reset_mid_redirect();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and flush controller for the 5-stage RV32I core.
- Produces `hazard_mux`, which the ID-stage control decoder consumes to emit a bubble, and acts on the decoder's `flush` indication (jal/jalr).
- Combines load-use detection, EX-stage taken-branch redirect, I-cache front-end stall and D-cache full freeze into PC / IF/ID / ID/EX / back-end control.
- Holds a pending redirect across an I-cache miss and keeps saturating stall/flush performance counters.

Parameters:
- `CNT_W`, 32, width of each saturating performance counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `icache_stall`  in  1  fetch not ready this cycle.
- `dcache_stall`  in  1  data access not ready this cycle.
- `id_rs1`  in  5  source reg 1 of the instruction in ID.
- `id_rs2`  in  5  source reg 2 of the instruction in ID.
- `id_use_rs1`  in  1  ID instruction reads rs1.
- `id_use_rs2`  in  1  ID instruction reads rs2.
- `ex_memread`  in  1  EX instruction is a load.
- `ex_rd`  in  5  destination reg of the EX instruction.
- `id_flush`  in  1  decoder flush (jal/jalr in ID).
- `id_target`  in  32  jump target computed in ID.
- `ex_branch_taken`  in  1  branch resolved taken in EX (predict not-taken).
- `ex_target`  in  32  branch target from EX.
- `pc_write`  out  1  PC register load enable.
- `pc_redirect`  out  1  PC loads `redirect_pc` instead of PC+4.
- `redirect_pc`  out  32  redirect address.
- `ifid_write`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  IF/ID cleared to NOP; dominates `ifid_write`.
- `hazard_mux`  out  1  decoder forces all controls to 0 (bubble into ID/EX).
- `back_stall`  out  1  freeze ID/EX, EX/MEM, MEM/WB.
- `stall_cnt`  out  `CNT_W`  stall cycles.
- `flush_cnt`  out  `CNT_W`  redirect events.

Behaviour:
- **Reset.** `rst` is synchronous and active-high. On reset: state=RUN, `redir_q`=0, both counters=0.
- **Outputs during reset.** While `rst`=1, outputs are forced: `hazard_mux`=1, `ifid_flush`=1, all others 0.
- **Output timing.** Outputs are combinational from (state, inputs). State, `redir_q` and counters are registered.
- **load_use** = `ex_memread` & (`ex_rd`≠0) & ((`id_use_rs1` & `ex_rd`==`id_rs1`) | (`id_use_rs2` & `ex_rd`==`id_rs2`)).
- **States:** RUN, IWAIT (I-miss, no redirect pending), IWAIT_R (I-miss, redirect held in `redir_q`).
- **Defaults:** all outputs 0, except `pc_write`=1 and `ifid_write`=1.

Output priority (highest first):
1. `dcache_stall`=1 (any state)
   - `back_stall`=1, `pc_write`=0, `ifid_write`=0, `hazard_mux`=0, `ifid_flush`=0, `pc_redirect`=0.
   - State and `redir_q` hold; no capture.
2. State IWAIT_R with `icache_stall`=0
   - `pc_redirect`=1, `redirect_pc`=`redir_q`, `ifid_flush`=1, `hazard_mux`=1.
   - Next state RUN.
3. `icache_stall`=1
   - `pc_write`=0, `ifid_write`=0, `hazard_mux`=1; the ID instruction waits in ID.
   - If `ex_branch_taken` and state≠IWAIT_R: `redir_q`←`ex_target`, `ifid_flush`=1, next state IWAIT_R.
   - Else next state IWAIT (stays IWAIT_R if already there).
   - `id_flush` is ignored; a second taken branch in IWAIT_R is ignored (first capture wins).
4. `ex_branch_taken`
   - `pc_redirect`=1, `redirect_pc`=`ex_target`, `ifid_flush`=1, `hazard_mux`=1.
   - Overrides load_use and `id_flush`.
5. load_use
   - `hazard_mux`=1, `pc_write`=0, `ifid_write`=0; `id_flush` ignored.
6. `id_flush`
   - `pc_redirect`=1, `redirect_pc`=`id_target`, `ifid_flush`=1, `hazard_mux`=0; the jump issues.
7. Otherwise: defaults.

State return and counters:
- IWAIT with `icache_stall`=0 applies rules 4–7 the same cycle, next state RUN.
- `stall_cnt` += 1 per cycle with (`icache_stall` | `dcache_stall` | rule 5 active).
- `flush_cnt` += 1 per cycle with `pc_redirect`=1.
- Both counters saturate at all-ones; both are frozen while `rst`=1.
- `redirect_pc`=0 whenever `pc_redirect`=0.

Test Plan:
- **Load-use:** `ex_memread`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 for one cycle → `hazard_mux`=1, `pc_write`=0, `ifid_write`=0; `stall_cnt` 0→1. Same stimulus with `ex_rd`=0 → no stall.
- **Taken branch:** `ex_branch_taken`=1, `ex_target`=0x0000_0100, coincident with load_use and `id_flush` → `pc_redirect`=1, `redirect_pc`=0x100, `ifid_flush`=1, `hazard_mux`=1; `flush_cnt` +1.
- **jal:** `id_flush`=1, `id_target`=0x0000_0040 → `pc_redirect`=1, `redirect_pc`=0x40, `ifid_flush`=1, `hazard_mux`=0.
- **I-miss with branch:** `icache_stall`=1 for 4 cycles, `ex_branch_taken`=1, `ex_target`=0x200 in cycle 2.
  - Cycle 2: `ifid_flush`=1, `pc_write`=0.
  - First cycle after `icache_stall` falls: `pc_redirect`=1, `redirect_pc`=0x200, `ifid_flush`=1.
  - `stall_cnt`=4, `flush_cnt`=1.
- **D-miss priority:** `dcache_stall`=1 together with `icache_stall`=1 and `ex_branch_taken`=1 → `back_stall`=1, all other outputs 0, state unchanged. Releasing `dcache_stall` then applies rule 3 normally.
- **Reset mid-redirect:** assert `rst` while in IWAIT_R (`redir_q`=0x200) → next cycle state RUN, `redir_q`=0, counters 0; during reset `hazard_mux`=1, `ifid_flush`=1, `pc_write`=0.
